irq_capture: RTL and testbench

IRQ_CAPTURE -- requirements
Module: irq_capture

---
 rtl/irq_capture.sv | 85 ++++++++
 tb/tb_irq_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_capture.sv
// Interrupt request capture: per-line rising-edge detect, pending/mask/ack bookkeeping
// and sticky overflow flags. Define IRQ_CAPTURE_SYNC_EN to add a two-flop input synchronizer.
module irq_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  input  logic       ovf_clr,
  output logic [7:0] pend,
  output logic       any,
  output logic [7:0] ovf
);

  logic [7:0] edgeSrc;
  logic [7:0] hist_q;
  logic [7:0] rise;
  logic [7:0] ackVec;
  logic [7:0] pending_q, pending_d;
  logic [7:0] ovf_q, ovf_d;
  logic [7:0] mask_q, mask_d;

`ifdef IRQ_CAPTURE_SYNC_EN
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req_in;
      sync2_q <= sync1_q;
    end
  end

  assign edgeSrc = sync2_q;
`else
  assign edgeSrc = req_in;
`endif

  // History clears on reset so a line held high through reset release still yields one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= edgeSrc;
    end
  end

  assign rise = edgeSrc & ~hist_q;

  always_comb begin
    ackVec = '0;
    if (ack) begin
      ackVec[ack_idx] = 1'b1;
    end
  end

  // Set dominates ack, and a new overflow dominates ovf_clr, so no event is ever lost.
  always_comb begin
    pending_d = (pending_q & ~ackVec) | rise;
    ovf_d     = (ovf_q & ~{8{ovf_clr}}) | (rise & pending_q & ~ackVec);
    mask_d    = mask_wr ? mask_in : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
    end
  end

  assign pend = pending_q & ~mask_q;
  assign any  = |pend;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_irq_capture.sv
// Directed self-checking bench for irq_capture; expected values are hand-computed and
// the edge latency follows IRQ_CAPTURE_SYNC_EN.
module tb_irq_capture;

`ifdef IRQ_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       ack;
  logic [2:0] ack_idx;
  logic       ovf_clr;
  logic [7:0] pend;
  logic       any;
  logic [7:0] ovf;

  int errors = 0;
  int checks = 0;

  irq_capture dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_in (req_in),
    .mask_wr(mask_wr),
    .mask_in(mask_in),
    .ack    (ack),
    .ack_idx(ack_idx),
    .ovf_clr(ovf_clr),
    .pend   (pend),
    .any    (any),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One rising edge on the lines in val, landing on the same clock edge as the given ack/ovf_clr.
  task automatic applyStimulus(input logic [7:0] val, input logic ackEn, input logic [2:0] idx,
                               input logic clrEn);
    req_in = val;
    repeat (LAT) step();
    ack     = ackEn;
    ack_idx = idx;
    ovf_clr = clrEn;
    step();
    ack     = 1'b0;
    ovf_clr = 1'b0;
    req_in  = 8'h00;
    repeat (LAT + 2) step();
  endtask

  task automatic doAck(input logic [2:0] idx);
    ack     = 1'b1;
    ack_idx = idx;
    step();
    ack     = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    req_in  = 8'h00;
    mask_wr = 1'b0;
    mask_in = 8'h00;
    ack     = 1'b0;
    ack_idx = 3'd0;
    ovf_clr = 1'b0;
    repeat (3) step();
    checkOutput("reset_pend", pend, 8'h00);
    checkOutput("reset_any", {7'b0, any}, 8'h00);
    checkOutput("reset_ovf", ovf, 8'h00);
    rst_n = 1'b1;
    step();

    // Held level produces exactly one event.
    req_in = 8'h80;
    repeat (LAT) step();
    checkOutput("held_before_edge", pend, 8'h00);
    step();
    checkOutput("held_pend", pend, 8'h80);
    checkOutput("held_any", {7'b0, any}, 8'h01);
    repeat (20) step();
    checkOutput("held_pend_20", pend, 8'h80);
    checkOutput("held_ovf_20", ovf, 8'h00);
    doAck(3'd7);
    checkOutput("held_acked", pend, 8'h00);
    repeat (5) step();
    checkOutput("held_no_reevent", pend, 8'h00);
    req_in = 8'h00;
    repeat (LAT + 2) step();

    // Two lines in one cycle, acked one at a time.
    applyStimulus(8'h05, 1'b0, 3'd0, 1'b0);
    checkOutput("dual_pend", pend, 8'h05);
    doAck(3'd0);
    checkOutput("ack0_pend", pend, 8'h04);
    doAck(3'd2);
    checkOutput("ack2_pend", pend, 8'h00);
    checkOutput("ack2_any", {7'b0, any}, 8'h00);

    // Masked bit is recorded and appears once unmasked.
    mask_wr = 1'b1;
    mask_in = 8'h10;
    step();
    mask_wr = 1'b0;
    applyStimulus(8'h10, 1'b0, 3'd0, 1'b0);
    checkOutput("masked_pend", pend, 8'h00);
    checkOutput("masked_any", {7'b0, any}, 8'h00);
    mask_wr = 1'b1;
    mask_in = 8'h00;
    step();
    mask_wr = 1'b0;
    checkOutput("unmasked_pend", pend, 8'h10);
    checkOutput("unmasked_any", {7'b0, any}, 8'h01);
    doAck(3'd4);

    // Ack of a non-pending bit is ignored.
    applyStimulus(8'h20, 1'b0, 3'd0, 1'b0);
    doAck(3'd0);
    checkOutput("ack_nonpend", pend, 8'h20);
    doAck(3'd5);
    checkOutput("ack5_pend", pend, 8'h00);

    // Overflow on a repeated edge, then clear.
    applyStimulus(8'h08, 1'b0, 3'd0, 1'b0);
    checkOutput("ovf_first_ovf", ovf, 8'h00);
    applyStimulus(8'h08, 1'b0, 3'd0, 1'b0);
    checkOutput("ovf_set", ovf, 8'h08);
    checkOutput("ovf_pend", pend, 8'h08);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", ovf, 8'h00);
    checkOutput("ovf_clr_pend", pend, 8'h08);
    doAck(3'd3);

    // Edge coinciding with ack on the same pending bit: set wins, no overflow.
    applyStimulus(8'h40, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h40, 1'b1, 3'd6, 1'b0);
    checkOutput("setack_pend", pend, 8'h40);
    checkOutput("setack_ovf", ovf, 8'h00);
    doAck(3'd6);
    checkOutput("setack_cleared", pend, 8'h00);

    // New overflow coinciding with ovf_clr keeps the flag.
    applyStimulus(8'h02, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h02, 1'b0, 3'd0, 1'b1);
    checkOutput("ovf_vs_clr", ovf, 8'h02);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    doAck(3'd1);

    // Mid-cycle reset with everything pending.
    applyStimulus(8'hFF, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h81, 1'b0, 3'd0, 1'b0);
    checkOutput("full_pend", pend, 8'hFF);
    checkOutput("full_ovf", ovf, 8'h81);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_pend", pend, 8'h00);
    checkOutput("async_any", {7'b0, any}, 8'h00);
    checkOutput("async_ovf", ovf, 8'h00);

    // Line held high through reset release gives one event afterwards.
    req_in = 8'h08;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (LAT + 1) step();
    checkOutput("post_reset_event", pend, 8'h08);
    repeat (10) step();
    checkOutput("post_reset_ovf", ovf, 8'h00);
    req_in = 8'h00;
    repeat (LAT + 2) step();
    checkOutput("post_reset_pend_hold", pend, 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
